// File: rtl/l1_event_scheduler.sv
// Purpose: round-robin scheduler issuing one-hot event pulses into the L1 layer and collecting its spike result.
// Latency: request to o_event is 2 cycles from idle; the result appears p_gap cycles after the issue pulse.
// Backpressure: requests latch as sticky pending flags; repeat requests on a pending channel are dropped and counted.
module l1_event_scheduler #(
  parameter int p_gap       = 6,
  parameter int p_cnt_width = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic [4:1]             i_event_req,
  input  logic [6:1]             i_spike_out,
  output logic [4:1]             o_event,
  output logic                   o_busy,
  output logic [4:1]             o_pending,
  output logic [6:1]             o_result,
  output logic                   o_result_valid,
  output logic [4:1]             o_result_chan,
  output logic [p_cnt_width-1:0] o_drop_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [p_cnt_width-1:0] lp_one      = {{(p_cnt_width-1){1'b0}}, 1'b1};
  localparam logic [p_cnt_width-1:0] lp_gap_load = p_cnt_width'(p_gap - 1);
  localparam logic [p_cnt_width-1:0] lp_cnt_max  = {p_cnt_width{1'b1}};

  // Internal vectors use [3:0]; bit 0 is channel 1.
  logic [1:0]             r_state;
  logic [3:0]             r_pending;
  logic [1:0]             r_rr_idx;
  logic [3:0]             r_grant;
  logic [p_cnt_width-1:0] r_gap_cnt;
  logic [5:0]             r_acc;
  logic [3:0]             r_event;
  logic [5:0]             r_result;
  logic                   r_result_valid;
  logic [3:0]             r_result_chan;
  logic [p_cnt_width-1:0] r_drop_cnt;

  logic [3:0]             w_sel;
  logic [1:0]             w_sel_idx;
  logic                   w_found;
  logic                   w_grant_go;
  logic [3:0]             w_grant_vec;
  logic [3:0]             w_drops;
  logic [2:0]             w_drop_num;
  logic [p_cnt_width+2:0] w_drop_sum;

  // Pick the first pending channel at or after the round-robin pointer, wrapping 4 -> 1.
  always_comb begin
    logic [1:0] v_idx;
    v_idx     = r_rr_idx;
    w_sel     = 4'b0000;
    w_sel_idx = r_rr_idx;
    w_found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      v_idx = r_rr_idx + 2'(k);
      if (!w_found && r_pending[v_idx]) begin
        w_found       = 1'b1;
        w_sel[v_idx]  = 1'b1;
        w_sel_idx     = v_idx;
      end
    end
  end

  // The cycle that presents a result is a recovery cycle: no grant is taken there,
  // which sets the issue-to-issue spacing to p_gap+2.
  assign w_grant_go  = (r_state == S_IDLE) && i_enable && w_found && !r_result_valid;
  assign w_grant_vec = w_grant_go ? w_sel : 4'b0000;

  // A request on a channel that stays pending this cycle has nowhere to go.
  assign w_drops    = i_event_req & r_pending & ~w_grant_vec;
  assign w_drop_num = {2'b00, w_drops[0]} + {2'b00, w_drops[1]} +
                      {2'b00, w_drops[2]} + {2'b00, w_drops[3]};
  assign w_drop_sum = {3'b000, r_drop_cnt} + {{p_cnt_width{1'b0}}, w_drop_num};

  // Sticky pending flags and saturating drop counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending  <= 4'b0000;
      r_drop_cnt <= '0;
    end else begin
      r_pending <= (r_pending & ~w_grant_vec) | i_event_req;
      if (w_drop_sum > {3'b000, lp_cnt_max}) begin
        r_drop_cnt <= lp_cnt_max;
      end else begin
        r_drop_cnt <= w_drop_sum[p_cnt_width-1:0];
      end
    end
  end

  // Issue / settle-window / result FSM.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_rr_idx       <= 2'd0;
      r_grant        <= 4'b0000;
      r_gap_cnt      <= '0;
      r_acc          <= 6'b000000;
      r_event        <= 4'b0000;
      r_result       <= 6'b000000;
      r_result_valid <= 1'b0;
      r_result_chan  <= 4'b0000;
    end else begin
      r_event        <= 4'b0000;
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_go) begin
            r_state   <= S_ISSUE;
            r_grant   <= w_sel;
            r_event   <= w_sel;
            r_rr_idx  <= w_sel_idx + 2'd1;
            r_acc     <= 6'b000000;
            r_gap_cnt <= lp_gap_load;
          end
        end
        S_ISSUE, S_WAIT: begin
          // With p_gap=2 the counter is already 1 in ISSUE and the window skips WAIT.
          r_acc     <= r_acc | i_spike_out;
          r_gap_cnt <= r_gap_cnt - lp_one;
          r_state   <= (r_gap_cnt == lp_one) ? S_DONE : S_WAIT;
        end
        default: begin
          r_result       <= r_acc | i_spike_out;
          r_result_chan  <= r_grant;
          r_result_valid <= 1'b1;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

  assign o_event        = r_event;
  assign o_busy         = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign o_pending      = r_pending;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_result_chan  = r_result_chan;
  assign o_drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_l1_event_scheduler.sv
// Directed bench for l1_event_scheduler with event/result scoreboard queues.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected events and results are queued with their due cycle when stimulus is driven.
module tb_l1_event_scheduler;

  localparam int GAP = 6;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_enable;
  logic [4:1] i_event_req;
  logic [6:1] i_spike_out;
  logic [4:1] o_event;
  logic       o_busy;
  logic [4:1] o_pending;
  logic [6:1] o_result;
  logic       o_result_valid;
  logic [4:1] o_result_chan;
  logic [7:0] o_drop_cnt;

  always #5 i_clk = ~i_clk;

  l1_event_scheduler #(.p_gap(GAP), .p_cnt_width(8)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_enable       (i_enable),
    .i_event_req    (i_event_req),
    .i_spike_out    (i_spike_out),
    .o_event        (o_event),
    .o_busy         (o_busy),
    .o_pending      (o_pending),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .o_result_chan  (o_result_chan),
    .o_drop_cnt     (o_drop_cnt)
  );

  typedef struct {int c; logic [3:0] v;} ev_t;
  typedef struct {int c; logic [5:0] r; logic [3:0] ch;} res_t;

  ev_t        ev_q[$];
  res_t       res_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc   = 0;
  int         c0;
  int         c1;
  logic [3:0] prev_ev = 4'b0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input int c, input logic [3:0] v);
    ev_t e;
    e.c = c;
    e.v = v;
    ev_q.push_back(e);
  endtask

  task automatic push_res(input int c, input logic [5:0] r, input logic [3:0] ch);
    res_t e;
    e.c  = c;
    e.r  = r;
    e.ch = ch;
    res_q.push_back(e);
  endtask

  // Compare any event pulse or result pulse against the head of its queue.
  task automatic monitor();
    if (o_event !== 4'b0000) begin
      chk("event_onehot", 32'($onehot(o_event)), 32'd1);
      chk("event_back_to_back", 32'(prev_ev), 32'd0);
      if (ev_q.size() == 0) begin
        chk("event_unexpected", 32'(o_event), 32'd0);
      end else begin
        ev_t e;
        e = ev_q.pop_front();
        chk("event_cycle", cyc, e.c);
        chk("event_value", 32'(o_event), 32'(e.v));
      end
    end
    prev_ev = o_event;
    if (o_result_valid !== 1'b0) begin
      if (res_q.size() == 0) begin
        chk("result_unexpected", 32'(o_result_valid), 32'd0);
      end else begin
        res_t e;
        e = res_q.pop_front();
        chk("result_cycle", cyc, e.c);
        chk("result_value", 32'(o_result), 32'(e.r));
        chk("result_chan", 32'(o_result_chan), 32'(e.ch));
      end
    end
  endtask

  task automatic step();
    @(negedge i_clk);
    cyc++;
    monitor();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    ev_q.delete();
    res_q.delete();
    prev_ev = 4'b0000;
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_events_left"}, ev_q.size(), 0);
    chk({tag, "_results_left"}, res_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_event"}, 32'(o_event), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_pending"}, 32'(o_pending), 32'd0);
    chk({tag, "_result"}, 32'(o_result), 32'd0);
    chk({tag, "_valid"}, 32'(o_result_valid), 32'd0);
    chk({tag, "_chan"}, 32'(o_result_chan), 32'd0);
    chk({tag, "_drop"}, 32'(o_drop_cnt), 32'd0);
  endtask

  initial begin
    i_rst       = 1'b1;
    i_enable    = 1'b1;
    i_event_req = 4'b0000;
    i_spike_out = 6'b000000;
    step();
    check_all_zero("reset");
    step();
    i_rst = 1'b0;

    // Single request on channel 2.
    c0 = cyc;
    i_event_req = 4'b0010;
    push_ev(c0 + 2, 4'b0010);
    push_res(c0 + 2 + GAP, 6'b000000, 4'b0010);
    step();
    i_event_req = 4'b0000;
    chk("t1_pending", 32'(o_pending), 32'h2);
    step();
    chk("t1_busy_issue", 32'(o_busy), 32'd1);
    steps(6);
    chk("t1_busy_after", 32'(o_busy), 32'd0);
    steps(4);
    check_drained("t1");

    // All four channels at once: round-robin order, spacing p_gap+2.
    do_reset();
    c0 = cyc;
    i_event_req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      push_ev(c0 + 2 + i * (GAP + 2), 4'(1 << i));
      push_res(c0 + 2 + GAP + i * (GAP + 2), 6'b000000, 4'(1 << i));
    end
    step();
    i_event_req = 4'b0000;
    chk("t2_pending", 32'(o_pending), 32'hF);
    steps(33);
    chk("t2_drop", 32'(o_drop_cnt), 32'd0);
    check_drained("t2");

    // Drops on channel 3 while pending, then a re-request in its own grant cycle.
    do_reset();
    c0 = cyc;
    i_event_req = 4'b0001;
    push_ev(c0 + 2, 4'b0001);
    push_res(c0 + 8, 6'b000000, 4'b0001);
    step();
    i_event_req = 4'b0100;
    step();
    i_event_req = 4'b0000;
    step();
    i_event_req = 4'b0100;
    step();
    i_event_req = 4'b0100;
    step();
    i_event_req = 4'b0000;
    chk("t3_drop_two", 32'(o_drop_cnt), 32'd2);
    push_ev(c0 + 10, 4'b0100);
    push_res(c0 + 16, 6'b000000, 4'b0100);
    steps(4);
    i_event_req = 4'b0100;
    push_ev(c0 + 18, 4'b0100);
    push_res(c0 + 24, 6'b000000, 4'b0100);
    step();
    i_event_req = 4'b0000;
    chk("t3_repended", 32'(o_pending), 32'h4);
    chk("t3_drop_same_cycle", 32'(o_drop_cnt), 32'd2);
    steps(15);
    chk("t3_drop_final", 32'(o_drop_cnt), 32'd2);
    chk("t3_pending_final", 32'(o_pending), 32'd0);
    check_drained("t3");

    // Spike accumulation over the window, including the DONE cycle.
    do_reset();
    c0 = cyc;
    i_event_req = 4'b0001;
    push_ev(c0 + 2, 4'b0001);
    push_res(c0 + 8, 6'b100101, 4'b0001);
    step();
    i_event_req = 4'b0000;
    i_spike_out = 6'b111111;
    step();
    i_spike_out = 6'b000000;
    step();
    step();
    i_spike_out = 6'b000100;
    step();
    i_spike_out = 6'b000000;
    step();
    i_spike_out = 6'b100000;
    step();
    i_spike_out = 6'b000001;
    step();
    i_spike_out = 6'b111111;
    step();
    i_spike_out = 6'b000000;
    chk("t4_valid_one_cycle", 32'(o_result_valid), 32'd0);
    chk("t4_result_held", 32'(o_result), 32'h25);
    chk("t4_chan_held", 32'(o_result_chan), 32'h1);
    check_drained("t4");

    // Enable low blocks grants while requests still latch.
    do_reset();
    i_enable = 1'b0;
    i_event_req = 4'b0101;
    step();
    i_event_req = 4'b0000;
    steps(5);
    chk("t5_pending_held", 32'(o_pending), 32'h5);
    chk("t5_no_event", 32'(o_event), 32'd0);
    chk("t5_not_busy", 32'(o_busy), 32'd0);
    c1 = cyc;
    i_enable = 1'b1;
    push_ev(c1 + 1, 4'b0001);
    push_res(c1 + 7, 6'b000000, 4'b0001);
    push_ev(c1 + 9, 4'b0100);
    push_res(c1 + 15, 6'b000000, 4'b0100);
    steps(16);
    check_drained("t5");

    // Asynchronous reset in the middle of WAIT.
    do_reset();
    c0 = cyc;
    i_event_req = 4'b0010;
    push_ev(c0 + 2, 4'b0010);
    step();
    i_event_req = 4'b0001;
    step();
    i_event_req = 4'b0000;
    step();
    step();
    chk("t6_busy_before", 32'(o_busy), 32'd1);
    chk("t6_pending_before", 32'(o_pending), 32'h1);
    #2;
    i_rst = 1'b1;
    #1;
    check_all_zero("t6_async");
    ev_q.delete();
    res_q.delete();
    step();
    i_rst = 1'b0;
    c1 = cyc;
    i_event_req = 4'b1000;
    push_ev(c1 + 2, 4'b1000);
    push_res(c1 + 8, 6'b000000, 4'b1000);
    step();
    i_event_req = 4'b0000;
    steps(9);
    check_drained("t6");

    // Drop counter saturation with four drops per cycle.
    do_reset();
    i_enable = 1'b0;
    i_event_req = 4'b1111;
    step();
    chk("t7_drop_first", 32'(o_drop_cnt), 32'd0);
    step();
    chk("t7_drop_four", 32'(o_drop_cnt), 32'd4);
    steps(62);
    chk("t7_drop_252", 32'(o_drop_cnt), 32'd252);
    step();
    chk("t7_drop_sat", 32'(o_drop_cnt), 32'hFF);
    steps(3);
    chk("t7_drop_stays", 32'(o_drop_cnt), 32'hFF);
    i_event_req = 4'b0000;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
